out_reg_sequencer: RTL

//   Controller for the matrix-multiplier output shift register (ROWS chunks of ROW_W bits).

---
 rtl/matmul_defs.sv | 16 +
 rtl/out_reg_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/matmul_defs.sv
// Shared definitions for the matrix-multiplier output path: sequencer state
// encodings and default geometry of the output shift register.
package matmul_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_FULL  = 2'd3
    } seq_state_e;

    localparam int ROWS_DEF  = 128;
    localparam int ROW_W_DEF = 32;
    localparam int CNT_W_DEF = $clog2(ROWS_DEF);

endpackage

// File: rtl/out_reg_sequencer.sv
// Clears the output shift register, then takes one result row per valid/ready
// handshake (one shift each) and holds the full result until result_ack.
module out_reg_sequencer
    import matmul_defs::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             reg_clear,
    output logic             reg_shift,
    output logic [CNT_W-1:0] row_count,
    output logic             busy,
    output logic             done,
    input  logic             result_ack
);

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // abort wins over everything, including a simultaneous accept or ack
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
                ST_FILL: begin
                    if (accept) begin
                        if (cnt_q == LAST_ROW) begin
                            cnt_d   = '0;
                            state_d = ST_FULL;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (result_ack) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        row_ready = 1'b0;
        reg_clear = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_CLEAR: reg_clear = 1'b1;
            ST_FILL:  row_ready = 1'b1;
            ST_FULL:  done      = 1'b1;
            default:  ;
        endcase
    end

    assign accept    = row_valid & row_ready;
    assign reg_shift = accept & ~abort;
    assign row_count = cnt_q;

    shift_only_in_fill: assert property (@(posedge clk) disable iff (!rst_n)
        reg_shift |-> (state_q == ST_FILL));
    count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= LAST_ROW);

endmodule
